// File: rtl/traffic_pkg.sv
// Light-code constants and pedestrian state encoding, shared by the traffic-light sequencer and the pedestrian controller.
package traffic_pkg;

  localparam int unsigned LIGHT_W = 3;

  localparam logic [LIGHT_W-1:0] LIGHT_OFF    = 3'd0;
  localparam logic [LIGHT_W-1:0] LIGHT_RED    = 3'd1;
  localparam logic [LIGHT_W-1:0] LIGHT_GREEN  = 3'd2;
  localparam logic [LIGHT_W-1:0] LIGHT_YELLOW = 3'd3;

  typedef enum logic [1:0] {
    PED_STOP  = 2'd0,
    PED_WALK  = 2'd1,
    PED_FLASH = 2'd2
  } ped_state_e;

  function automatic logic is_red(input logic [LIGHT_W-1:0] code);
    return code == LIGHT_RED;
  endfunction

endpackage

// File: rtl/light_edge_det.sv
// Registers the vehicle light code and strobes red_onset_c_o for the one cycle in which red is first seen.
module light_edge_det
  import traffic_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [LIGHT_W-1:0] light_i,
  output logic               red_onset_c_o
);

  logic [LIGHT_W-1:0] light_q;

  always_ff @(posedge clk) begin
    if (!rst) light_q <= LIGHT_OFF;
    else      light_q <= light_i;
  end

  assign red_onset_c_o = is_red(light_i) && !is_red(light_q);

endmodule

// File: rtl/ped_signal_ctrl.sv
// Pedestrian signal controller: grants WALK at vehicle red onset, then an optional flashing clearance phase.
// Define PED_FLASH_CLEAR_EN to build the FLASH clearance phase; otherwise WALK returns straight to STOP.
module ped_signal_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned WALK_CYC  = 4,
  parameter int unsigned FLASH_CYC = 3,
  parameter int unsigned CNT_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LIGHT_W-1:0] light,
  input  logic               ped_btn,
  output logic               walk,
  output logic               dont_walk,
  output logic               flash,
  output logic               req_pending,
  output logic [CNT_W-1:0]   countdown,
  output logic               aborted
);

`ifdef PED_FLASH_CLEAR_EN
  localparam int unsigned CLEAR_CYC = FLASH_CYC;
`else
  localparam int unsigned CLEAR_CYC = 0;
  logic unused_flash_cyc;
  assign unused_flash_cyc = ^32'(FLASH_CYC);
`endif

  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(WALK_CYC + CLEAR_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST_WALK = CNT_W'(CLEAR_CYC + 1);

  ped_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             flash_q, flash_d;
  logic             aborted_q, aborted_d;
  logic             walk_q, walk_d;
  logic             dont_walk_q, dont_walk_d;
  logic             red_onset_c;
  logic             red_c;

  light_edge_det u_edge (
    .clk           (clk),
    .rst           (rst),
    .light_i       (light),
    .red_onset_c_o (red_onset_c)
  );

  assign red_c = is_red(light);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= PED_STOP;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      flash_q     <= 1'b0;
      aborted_q   <= 1'b0;
      walk_q      <= 1'b0;
      dont_walk_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      flash_q     <= flash_d;
      aborted_q   <= aborted_d;
      walk_q      <= walk_d;
      dont_walk_q <= dont_walk_d;
    end
  end

  // Losing red mid-crossing always wins over normal progression.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    flash_d   = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      PED_STOP: begin
        if (ped_btn) req_d = 1'b1;
        if (red_onset_c && (req_q || ped_btn)) begin
          state_d = PED_WALK;
          cnt_d   = CNT_START;
          req_d   = 1'b0;
        end
      end
      PED_WALK: begin
        if (!red_c) begin
          state_d   = PED_STOP;
          cnt_d     = '0;
          aborted_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_LAST_WALK) begin
`ifdef PED_FLASH_CLEAR_EN
            state_d = PED_FLASH;
            flash_d = 1'b1;
`else
            state_d = PED_STOP;
            cnt_d   = '0;
`endif
          end
        end
      end
`ifdef PED_FLASH_CLEAR_EN
      PED_FLASH: begin
        if (ped_btn) req_d = 1'b1;
        if (!red_c) begin
          state_d   = PED_STOP;
          cnt_d     = '0;
          aborted_d = 1'b1;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = PED_STOP;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          flash_d = !flash_q;
        end
      end
`endif
      default: begin
        state_d = PED_STOP;
        cnt_d   = '0;
      end
    endcase
    walk_d      = (state_d == PED_WALK);
    dont_walk_d = (state_d != PED_WALK);
  end

  assign walk        = walk_q;
  assign dont_walk   = dont_walk_q;
  assign flash       = flash_q;
  assign req_pending = req_q;
  assign countdown   = cnt_q;
  assign aborted     = aborted_q;

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Bench for ped_signal_ctrl: crossing-age reference model checked every cycle, plus directed literal expectations.
module tb_ped_signal_ctrl;

  localparam int unsigned WALK  = 4;
  localparam int unsigned FLSH  = 3;
`ifdef PED_FLASH_CLEAR_EN
  localparam bit          FLASH_EN = 1'b1;
  localparam int unsigned TOTAL    = WALK + FLSH;
`else
  localparam bit          FLASH_EN = 1'b0;
  localparam int unsigned TOTAL    = WALK;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] light;
  logic       ped_btn;
  logic       walk, dont_walk, flash, req_pending, aborted;
  logic [3:0] countdown;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ped_signal_ctrl #(.WALK_CYC(WALK), .FLASH_CYC(FLSH), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .light       (light),
    .ped_btn     (ped_btn),
    .walk        (walk),
    .dont_walk   (dont_walk),
    .flash       (flash),
    .req_pending (req_pending),
    .countdown   (countdown),
    .aborted     (aborted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a crossing is described only by its age in cycles since the grant.
  bit         m_cross, m_req, m_abort;
  int         m_age;
  logic [2:0] m_prev;
  logic       m_onset, m_btn_ok;
  logic [9:0] m_exp, m_act;

  always @(posedge clk) begin
    m_onset  = (light == 3'd1) && (m_prev != 3'd1);
    m_btn_ok = !m_cross || (FLASH_EN && m_age >= WALK);
    if (!rst) begin
      m_cross = 0; m_req = 0; m_abort = 0; m_age = 0;
      m_prev  = 3'd0;
    end else begin
      m_abort = 0;
      if (m_btn_ok && ped_btn) m_req = 1;
      if (m_cross) begin
        if (light != 3'd1) begin m_cross = 0; m_abort = 1; end
        else if (m_age + 1 == TOTAL) m_cross = 0;
        else m_age++;
      end else if (m_onset && m_req) begin
        m_cross = 1; m_age = 0; m_req = 0;
      end
      m_prev = light;
    end
    #1;
    m_exp[9] = m_cross && (m_age < WALK);
    m_exp[8] = !(m_cross && (m_age < WALK));
    m_exp[7] = m_cross && (m_age >= WALK) && (((m_age - WALK) % 2) == 0);
    m_exp[6] = m_req;
    m_exp[5:2] = m_cross ? 4'(TOTAL - m_age) : 4'd0;
    m_exp[1] = m_abort;
    m_exp[0] = 1'b0;
    m_act = {walk, dont_walk, flash, req_pending, countdown, aborted, 1'b0};
    chk("model_outputs", 32'(m_act), 32'(m_exp));
  end

  // Apply inputs at a falling edge; return at the falling edge after they were sampled.
  task automatic cyc(input logic [2:0] l, input logic b);
    light   = l;
    ped_btn = b;
    @(negedge clk);
  endtask

  int exp_cd[10];
  bit exp_walk[10];
  bit exp_flash[10];

  initial begin
    rst = 1'b0; light = 3'd1; ped_btn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      cyc(3'd1, 1'b1);
      chk("rst_dont_walk", 32'(dont_walk), 32'd1);
      chk("rst_walk", 32'(walk), 32'd0);
      chk("rst_countdown", 32'(countdown), 32'd0);
      chk("rst_req", 32'(req_pending), 32'd0);
    end
    rst = 1'b1;
    cyc(3'd2, 1'b0);

    // Normal crossing
    cyc(3'd2, 1'b1); chk("req_after_press", 32'(req_pending), 32'd1);
    cyc(3'd2, 1'b0); chk("req_held_green", 32'(req_pending), 32'd1);
    cyc(3'd3, 1'b0); chk("req_held_yellow", 32'(req_pending), 32'd1);
`ifdef PED_FLASH_CLEAR_EN
    exp_cd    = '{7, 6, 5, 4, 3, 2, 1, 0, 0, 0};
    exp_flash = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 0};
`else
    exp_cd    = '{4, 3, 2, 1, 0, 0, 0, 0, 0, 0};
    exp_flash = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
    exp_walk = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      cyc(3'd1, 1'b0);
      chk("cross_countdown", 32'(countdown), 32'(exp_cd[i]));
      chk("cross_walk", 32'(walk), 32'(exp_walk[i]));
      chk("cross_dont_walk", 32'(dont_walk), 32'(!exp_walk[i]));
      if (exp_cd[i] != 0 && !exp_walk[i]) chk("cross_flash", 32'(flash), 32'(exp_flash[i]));
      if (i == 0) chk("req_cleared_on_grant", 32'(req_pending), 32'd0);
    end

    // No request
    cyc(3'd2, 1'b0); cyc(3'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(3'd1, 1'b0);
      chk("noreq_walk", 32'(walk), 32'd0);
    end

    // Abort during WALK
    cyc(3'd2, 1'b1);
    cyc(3'd1, 1'b0); chk("abort_grant", 32'(walk), 32'd1);
    cyc(3'd1, 1'b0);
    cyc(3'd1, 1'b0);
`ifdef PED_FLASH_CLEAR_EN
    chk("abort_pre_cd", 32'(countdown), 32'd5);
`else
    chk("abort_pre_cd", 32'(countdown), 32'd2);
`endif
    cyc(3'd2, 1'b0);
    chk("abort_walk", 32'(walk), 32'd0);
    chk("abort_dont_walk", 32'(dont_walk), 32'd1);
    chk("abort_cd", 32'(countdown), 32'd0);
    chk("abort_pulse", 32'(aborted), 32'd1);
    cyc(3'd2, 1'b0);
    chk("abort_one_cycle", 32'(aborted), 32'd0);

    // Mid-red request waits for the next onset
    cyc(3'd1, 1'b0);
    cyc(3'd1, 1'b0); cyc(3'd1, 1'b0); cyc(3'd1, 1'b1);
    cyc(3'd1, 1'b0); chk("midred_no_grant", 32'(walk), 32'd0);
    chk("midred_req", 32'(req_pending), 32'd1);
    cyc(3'd2, 1'b0); chk("midred_req_green", 32'(req_pending), 32'd1);
    cyc(3'd3, 1'b0); chk("midred_req_yellow", 32'(req_pending), 32'd1);
    cyc(3'd1, 1'b0); chk("midred_grant", 32'(walk), 32'd1);

    // Button during WALK and FLASH
    cyc(3'd1, 1'b1); chk("walk_press_ignored", 32'(req_pending), 32'd0);
    cyc(3'd1, 1'b0); cyc(3'd1, 1'b0); cyc(3'd1, 1'b0);
`ifdef PED_FLASH_CLEAR_EN
    chk("in_flash", 32'(flash), 32'd1);
    cyc(3'd1, 1'b1);
    cyc(3'd1, 1'b0); cyc(3'd1, 1'b0);
    chk("flash_press_end_cd", 32'(countdown), 32'd0);
    chk("flash_press_req", 32'(req_pending), 32'd1);
`else
    chk("walk_end_cd", 32'(countdown), 32'd0);
    chk("walk_end_req", 32'(req_pending), 32'd0);
    chk("flash_tied_low", 32'(flash), 32'd0);
`endif
    cyc(3'd2, 1'b0);
    cyc(3'd1, 1'b0); chk("pending_grant", 32'(walk), 32'(FLASH_EN));
    cyc(3'd2, 1'b0);

    // Invalid codes in STOP retain the request
    cyc(3'd5, 1'b1); chk("invalid_req_set", 32'(req_pending), 32'd1);
    cyc(3'd0, 1'b0); chk("invalid_req_kept", 32'(req_pending), 32'd1);
    chk("invalid_stop", 32'(walk), 32'd0);
    cyc(3'd1, 1'b0); chk("invalid_then_grant", 32'(countdown), 32'(TOTAL));
    cyc(3'd1, 1'b0);

    // Reset mid-crossing: no abort pulse
    rst = 1'b0;
    cyc(3'd1, 1'b0);
    chk("rst_mid_walk", 32'(walk), 32'd0);
    chk("rst_mid_aborted", 32'(aborted), 32'd0);
    chk("rst_mid_cd", 32'(countdown), 32'd0);
    rst = 1'b1;
    cyc(3'd2, 1'b0);
    chk("rst_release_aborted", 32'(aborted), 32'd0);
    cyc(3'd2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
